// File: rtl/integral_pkg.sv
// -----------------------------------------------------------------------------
// integral_pkg
// Shared definitions for the integral-window front end:
//   - datapath widths (pixel and coordinate/counter)
//   - default window side length and camera frame dimensions
//   - frame-tracking state encoding
// -----------------------------------------------------------------------------
package integral_pkg;

  localparam int DATA_WIDTH_8  = 8;   // pixel width
  localparam int DATA_WIDTH_12 = 12;  // coordinate / counter width

  localparam int INTEGRAL_WIDTH_DEF      = 3;
  localparam int FRAME_CAMERA_WIDTH_DEF  = 10;
  localparam int FRAME_CAMERA_HEIGHT_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a frame start, pixels dropped
    ST_FILL = 2'd1,  // first INTEGRAL_WIDTH-1 rows being written
    ST_SCAN = 2'd2,  // full windows can complete
    ST_DONE = 2'd3   // last pixel seen, waiting for the next frame
  } state_e;

endpackage

// File: rtl/pos_counter.sv
// -----------------------------------------------------------------------------
// pos_counter
// Wrapping position counter (0..MAX) with enable and synchronous clear.
// The clear acts before the enable in the same cycle, so clr=1,en=1 counts
// the current event as position 0 and leaves the counter at 1.
//
// Ports:
//   clk_os    system clock
//   reset_os  synchronous active-high reset
//   clr       restart counting from 0 (this cycle's position reads 0)
//   en        advance by one position
//   value     effective position for this cycle (0 while clr is high)
//   tc        terminal count: en is high and value == MAX (wraps to 0)
// -----------------------------------------------------------------------------
module pos_counter #(
  parameter int WIDTH = 12,
  parameter int MAX   = 9
) (
  input  logic             clk_os,
  input  logic             reset_os,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    value   = clr ? '0 : cnt;
    tc      = en && (value == MAX_V);
    cnt_nxt = value;
    if (en) begin
      cnt_nxt = tc ? '0 : value + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of block ordering.
  always_ff @(posedge clk_os) begin
    if (reset_os) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/integral_window_ctrl.sv
// -----------------------------------------------------------------------------
// integral_window_ctrl
// Front end of the row integral line-buffer stage. Takes the raw camera
// pixel stream, tracks (row, col) inside the frame, forwards accepted pixels
// one cycle later with their coordinates, flags pixels that complete an
// INTEGRAL_WIDTH x INTEGRAL_WIDTH window, and pulses on the last pixel.
//
// Ports:
//   clk_os          system clock
//   reset_os        synchronous active-high reset
//   i_frame_start   pulse; the next (or coincident) valid pixel is (0,0)
//   i_pixel_valid   pixel qualifier
//   i_pixel         pixel value
//   o_wen           write enable to the row stage (1 cycle after accept)
//   o_fifo_in       pixel to the row stage
//   o_col, o_row    coordinates of the presented pixel
//   o_window_ready  window ending at (o_row, o_col) is complete
//   o_frame_done    pulse alongside the last pixel of the frame
//   o_busy          frame in progress (FILL or SCAN)
//   o_drop_cnt      saturating count of pixels dropped outside a frame
//                   (present only with INTEGRAL_WINDOW_CTRL_DROP_CNT_EN)
//
// Build option: define INTEGRAL_WINDOW_CTRL_DROP_CNT_EN to add o_drop_cnt.
// -----------------------------------------------------------------------------
module integral_window_ctrl
  import integral_pkg::*;
#(
  parameter int INTEGRAL_WIDTH      = INTEGRAL_WIDTH_DEF,
  parameter int FRAME_CAMERA_WIDTH  = FRAME_CAMERA_WIDTH_DEF,
  parameter int FRAME_CAMERA_HEIGHT = FRAME_CAMERA_HEIGHT_DEF
) (
  input  logic                     clk_os,
  input  logic                     reset_os,
  input  logic                     i_frame_start,
  input  logic                     i_pixel_valid,
  input  logic [DATA_WIDTH_8-1:0]  i_pixel,
  output logic                     o_wen,
  output logic [DATA_WIDTH_8-1:0]  o_fifo_in,
  output logic [DATA_WIDTH_12-1:0] o_col,
  output logic [DATA_WIDTH_12-1:0] o_row,
  output logic                     o_window_ready,
  output logic                     o_frame_done,
  output logic                     o_busy
`ifdef INTEGRAL_WINDOW_CTRL_DROP_CNT_EN
  ,
  output logic [DATA_WIDTH_12-1:0] o_drop_cnt
`endif
);

  // First row/column index at which a full window exists.
  localparam logic [DATA_WIDTH_12-1:0] WIN_LAST = DATA_WIDTH_12'(INTEGRAL_WIDTH - 1);

  state_e                   state;
  state_e                   state_nxt;
  logic                     accept;
  logic                     col_tc;
  logic                     row_tc;
  logic [DATA_WIDTH_12-1:0] col_val;
  logic [DATA_WIDTH_12-1:0] row_val;
  logic [DATA_WIDTH_12-1:0] row_after;

  // A frame start makes the coincident pixel the first pixel of a new frame,
  // whatever state we are in.
  assign accept = i_pixel_valid &&
                  (i_frame_start || (state == ST_FILL) || (state == ST_SCAN));

  pos_counter #(
    .WIDTH (DATA_WIDTH_12),
    .MAX   (FRAME_CAMERA_WIDTH - 1)
  ) u_col_cnt (
    .clk_os   (clk_os),
    .reset_os (reset_os),
    .clr      (i_frame_start),
    .en       (accept),
    .value    (col_val),
    .tc       (col_tc)
  );

  // Row advances on the column wrap; its own wrap marks the last pixel, and
  // both counters land back on 0 at that point.
  pos_counter #(
    .WIDTH (DATA_WIDTH_12),
    .MAX   (FRAME_CAMERA_HEIGHT - 1)
  ) u_row_cnt (
    .clk_os   (clk_os),
    .reset_os (reset_os),
    .clr      (i_frame_start),
    .en       (col_tc),
    .value    (row_val),
    .tc       (row_tc)
  );

  always_comb begin
    row_after = row_val;
    if (row_tc) begin
      row_after = '0;
    end else if (col_tc) begin
      row_after = row_val + DATA_WIDTH_12'(1);
    end

    state_nxt = state;
    if (accept) begin
      if (row_tc) begin
        state_nxt = ST_DONE;
      end else if (row_after >= WIN_LAST) begin
        state_nxt = ST_SCAN;
      end else begin
        state_nxt = ST_FILL;
      end
    end else if (i_frame_start) begin
      state_nxt = (WIN_LAST == '0) ? ST_SCAN : ST_FILL;
    end
  end

  // NOTE: reset is synchronous and covers every register that is visible on
  // a port, so a reset cycle also cancels the output in flight.
  always_ff @(posedge clk_os) begin
    if (reset_os) begin
      state          <= ST_IDLE;
      o_wen          <= 1'b0;
      o_fifo_in      <= '0;
      o_col          <= '0;
      o_row          <= '0;
      o_window_ready <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_wen          <= accept;
      o_window_ready <= accept && (col_val >= WIN_LAST) && (row_val >= WIN_LAST);
      o_frame_done   <= accept && row_tc;
      if (accept) begin
        o_fifo_in <= i_pixel;
        o_col     <= col_val;
        o_row     <= row_val;
      end
    end
  end

  assign o_busy = (state == ST_FILL) || (state == ST_SCAN);

`ifdef INTEGRAL_WINDOW_CTRL_DROP_CNT_EN
  // Without a frame start, a valid pixel that is not accepted means we are
  // in IDLE or DONE.
  always_ff @(posedge clk_os) begin
    if (reset_os || i_frame_start) begin
      o_drop_cnt <= '0;
    end else if (i_pixel_valid && !accept && (o_drop_cnt != '1)) begin
      o_drop_cnt <= o_drop_cnt + DATA_WIDTH_12'(1);
    end
  end
`endif

endmodule

// File: tb/tb_integral_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_integral_window_ctrl
// Randomised bench with a frame-level reference model: the model only knows
// "inside a frame or not" and the pixel index k inside the frame; expected
// coordinates come from k / width and k % width. Expected outputs are queued
// by the driver and popped by an independent monitor whenever o_wen is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_integral_window_ctrl;

  localparam int FW = 10;
  localparam int FH = 10;
  localparam int W  = 3;

  logic        clk_os = 1'b0;
  logic        reset_os = 1'b1;
  logic        i_frame_start = 1'b0;
  logic        i_pixel_valid = 1'b0;
  logic [7:0]  i_pixel = '0;
  logic        o_wen;
  logic [7:0]  o_fifo_in;
  logic [11:0] o_col;
  logic [11:0] o_row;
  logic        o_window_ready;
  logic        o_frame_done;
  logic        o_busy;
`ifdef INTEGRAL_WINDOW_CTRL_DROP_CNT_EN
  logic [11:0] o_drop_cnt;
`endif

  integral_window_ctrl #(
    .INTEGRAL_WIDTH      (W),
    .FRAME_CAMERA_WIDTH  (FW),
    .FRAME_CAMERA_HEIGHT (FH)
  ) dut (
    .clk_os         (clk_os),
    .reset_os       (reset_os),
    .i_frame_start  (i_frame_start),
    .i_pixel_valid  (i_pixel_valid),
    .i_pixel        (i_pixel),
    .o_wen          (o_wen),
    .o_fifo_in      (o_fifo_in),
    .o_col          (o_col),
    .o_row          (o_row),
    .o_window_ready (o_window_ready),
    .o_frame_done   (o_frame_done),
    .o_busy         (o_busy)
`ifdef INTEGRAL_WINDOW_CTRL_DROP_CNT_EN
    ,
    .o_drop_cnt     (o_drop_cnt)
`endif
  );

  always #5 clk_os = ~clk_os;

  int cyc = 0;
  always @(posedge clk_os) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] px;
    int         row;
    int         col;
    bit         win;
    bit         done;
  } exp_t;

  exp_t q[$];

  int exp_win  = 0;
  int act_win  = 0;
  int exp_done = 0;
  int act_done = 0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_os) begin
    if (o_wen) begin
      check("wen_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("wen_latency",  cyc, e.cyc);
        check("fifo_in",      o_fifo_in, e.px);
        check("row",          o_row, e.row);
        check("col",          o_col, e.col);
        check("window_ready", o_window_ready, e.win);
        check("frame_done",   o_frame_done, e.done);
      end
      if (o_window_ready) act_win++;
      if (o_frame_done)   act_done++;
    end else begin
      check("flags_without_wen", {o_window_ready, o_frame_done}, 0);
    end
  end

  // ------------------------------------------------------- reference model
  bit m_active = 0;  // inside a frame
  int m_idx    = 0;  // index of the next pixel in the frame
  int m_drops  = 0;

  task automatic step(input bit fs, input bit v, input bit rst, input logic [7:0] px);
    exp_t e;
    reset_os      = rst;
    i_frame_start = fs;
    i_pixel_valid = v;
    i_pixel       = px;
    if (rst) begin
      m_active = 0;
      m_idx    = 0;
      m_drops  = 0;
    end else begin
      if (fs) begin
        m_active = 1;
        m_idx    = 0;
        m_drops  = 0;
      end
      if (v) begin
        if (m_active) begin
          e.cyc  = cyc + 1;
          e.px   = px;
          e.row  = m_idx / FW;
          e.col  = m_idx % FW;
          e.win  = (e.row >= W - 1) && (e.col >= W - 1);
          e.done = (m_idx == FW * FH - 1);
          q.push_back(e);
          if (e.win)  exp_win++;
          if (e.done) exp_done++;
          m_idx++;
          if (e.done) begin
            m_active = 0;
            m_idx    = 0;
          end
        end else if (m_drops < 4095) begin
          m_drops++;
        end
      end
    end
    @(posedge clk_os);
    #1;
    check("busy", o_busy, m_active);
`ifdef INTEGRAL_WINDOW_CTRL_DROP_CNT_EN
    check("drop_cnt", o_drop_cnt, m_drops);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00);
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_windows"}, act_win, exp_win);
    check({tag, "_frame_done"}, act_done, exp_done);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int guard;
    @(posedge clk_os);
    #1;
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);

    // Reset state.
    check("rst_wen",    o_wen, 0);
    check("rst_fifo",   o_fifo_in, 0);
    check("rst_col",    o_col, 0);
    check("rst_row",    o_row, 0);
    check("rst_win",    o_window_ready, 0);
    check("rst_done",   o_frame_done, 0);
    check("rst_busy",   o_busy, 0);

    // Pixels before any frame start are dropped.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));

    // Full back-to-back frame, pixel = index mod 256.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < FW * FH; i++) step(0, 1, 0, 8'(i));
    idle(2);
    check("frame1_win_count", exp_win, 64);
    check_totals("frame1");

    // Pixels after DONE are dropped.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));

    // Gapped frame: valid every other cycle.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 2 * FW * FH; i++) step(0, (i % 2) == 0, 0, 8'($urandom));
    idle(2);
    check_totals("gapped");

    // Restart coincident with pixel 37, then a complete frame follows.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 37; i++) step(0, 1, 0, 8'($urandom));
    step(1, 1, 0, 8'($urandom));
    for (int i = 1; i < FW * FH; i++) step(0, 1, 0, 8'($urandom));
    idle(2);
    check_totals("restart");

    // Reset at pixel 55 with valid held high.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 55; i++) step(0, 1, 0, 8'($urandom));
    step(0, 1, 1, 8'($urandom));
    check("midrst_wen",  o_wen, 0);
    check("midrst_fifo", o_fifo_in, 0);
    check("midrst_col",  o_col, 0);
    check("midrst_row",  o_row, 0);
    check("midrst_busy", o_busy, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'($urandom));
    idle(1);
    check_totals("midrst");

    // Random-gap frame to reach DONE, then frame start with a coincident pixel.
    step(1, 0, 0, 8'h00);
    guard = 0;
    while (m_active && guard < 2000) begin
      step(0, $urandom_range(0, 3) != 0, 0, 8'($urandom));
      guard++;
    end
    check("random_frame_completed", m_active, 0);
    idle(1);
    step(1, 1, 0, 8'hA5);
    for (int i = 0; i < 20; i++) step(0, $urandom_range(0, 1) == 1, 0, 8'($urandom));
    idle(3);
    check_totals("final");
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
